// File: rtl/move_arbiter.sv
// move_arbiter
//   Converts debounced direction / new-game pulses into single move commands
//   for the board engine on a valid/ready handshake. Resolves simultaneous
//   presses (up > down > left > right), buffers one move while the engine is
//   busy, suppresses pulse trains with a lockout window and blocks moves
//   while the game is over.
//
// Ports
//   clk        in   system clock, posedge
//   rst        in   asynchronous, active-high reset
//   dir_pulse  in   [0]=up [1]=down [2]=left [3]=right
//   new_game   in   new-game pulse
//   game_over  in   level, high blocks captures and flushes the pending slot
//   move_valid out  move command valid
//   move_dir   out  0=up 1=down 2=left 3=right, stable while move_valid
//   move_ready in   engine accepts when move_valid && move_ready
//   move_done  in   engine finished the accepted move (only seen in WAIT)
//   start_new  out  one-cycle board re-initialisation request
//   move_count out  (MOVE_COUNT_EN only) saturating handshake counter
//   busy       out  high whenever the FSM is not idle
//
// Configuration
//   MOVE_COUNT_EN  adds move_count[15:0]; cleared by start_new.

module move_arbiter #(
    parameter int LOCKOUT_CYCLES = 16,
    parameter int LOCK_W         = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dir_pulse,
    input  logic        new_game,
    input  logic        game_over,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    input  logic        move_ready,
    input  logic        move_done,
    output logic        start_new,
`ifdef MOVE_COUNT_EN
    output logic [15:0] move_count,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_NEWG  = 2'd3
    } state_t;

    state_t            state;
    logic [LOCK_W-1:0] lockout;
    logic              ng_flag;
    logic              pend_valid;
    logic [1:0]        pend_dir;

    logic              cap;
    logic [1:0]        cap_dir;

    // Fixed priority: lowest set bit wins.
    always_comb begin
        cap_dir = 2'd0;
        if (dir_pulse[0])      cap_dir = 2'd0;
        else if (dir_pulse[1]) cap_dir = 2'd1;
        else if (dir_pulse[2]) cap_dir = 2'd2;
        else if (dir_pulse[3]) cap_dir = 2'd3;
    end

    assign cap = (|dir_pulse) && (lockout == '0) && !game_over && !ng_flag;

    // Lockout window: reloads on every capture, counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockout <= '0;
        end else if (cap) begin
            lockout <= LOCK_W'(LOCKOUT_CYCLES);
        end else if (lockout != '0) begin
            lockout <= lockout - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            start_new  <= 1'b0;
            busy       <= 1'b0;
            ng_flag    <= 1'b0;
            pend_valid <= 1'b0;
            pend_dir   <= 2'd0;
        end else begin
            if (new_game) begin
                ng_flag <= 1'b1;
            end

            // Captures while the engine is occupied go to the single slot;
            // a full slot keeps its first occupant.
            if ((state == S_ISSUE || state == S_WAIT) && cap && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_dir   <= cap_dir;
            end

            case (state)
                S_IDLE: begin
                    if (ng_flag) begin
                        state     <= S_NEWG;
                        start_new <= 1'b1;
                        busy      <= 1'b1;
                    end else if (pend_valid && !game_over) begin
                        // Buffered move goes first; a same-cycle capture
                        // refills the slot it just vacated.
                        state      <= S_ISSUE;
                        move_valid <= 1'b1;
                        move_dir   <= pend_dir;
                        busy       <= 1'b1;
                        pend_valid <= cap;
                        if (cap) begin
                            pend_dir <= cap_dir;
                        end
                    end else if (cap) begin
                        state      <= S_ISSUE;
                        move_valid <= 1'b1;
                        move_dir   <= cap_dir;
                        busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (move_ready) begin
                        state      <= S_WAIT;
                        move_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (move_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_NEWG: begin
                    state      <= S_IDLE;
                    start_new  <= 1'b0;
                    busy       <= 1'b0;
                    pend_valid <= 1'b0;
                    ng_flag    <= new_game;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // No captures happen while game_over is high, so clearing on the
            // level is the same as clearing on its rising edge.
            if (game_over) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef MOVE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_count <= '0;
        end else if (start_new) begin
            move_count <= '0;
        end else if (move_valid && move_ready && (move_count != 16'hFFFF)) begin
            move_count <= move_count + 16'd1;
        end
    end
`endif

endmodule
